// File: rtl/cv_mem_responder.sv
// Memory-side responder for the accelerator data-movement bus: serves reads and
// writes from a single-port word array with programmable latency and debug counters.
module cv_mem_responder #(
    parameter int unsigned           ADDR_W     = 26,
    parameter int unsigned           DATA_W     = 32,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0]     BASE       = '0,
    parameter int unsigned           RD_LAT     = 2,
    parameter int unsigned           WR_LAT     = 1,
    parameter string                 INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rvalid,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_rready,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_wvalid,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_wready,
    output logic              o_busy,
    output logic              o_err_oob,
    output logic [31:0]       o_rd_count,
    output logic [31:0]       o_wr_count
);

    localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
    localparam int unsigned LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_WAIT,
        S_WR_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_accept_rd;
    logic                  w_accept_wr;
    logic [ADDR_W-1:0]     w_req_addr;
    logic [ADDR_W-1:0]     w_off;
    logic                  w_in_range;
    logic                  w_rd_done;
    logic                  w_wr_done;

    logic [LAT_W-1:0]      r_lat_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_in_range;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_last_wr;
    logic                  r_rready;
    logic                  r_wready;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_busy;
    logic                  r_err_oob;
    logic [CNT_W-1:0]      r_rd_count;
    logic [CNT_W-1:0]      r_wr_count;

    logic [DATA_W-1:0]     r_mem [DEPTH];

    // Address decode of whichever request wins arbitration.
    assign w_req_addr = w_accept_wr ? i_waddr : i_raddr;
    assign w_off      = w_req_addr - BASE;
    assign w_in_range = (w_req_addr >= BASE) && (w_off[ADDR_W-1:DEPTH_LOG2] == '0);

    // Next-state and arbitration; write wins a tie unless the last accept was a write.
    always_comb begin
        w_next_state = r_state;
        w_accept_rd  = 1'b0;
        w_accept_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_wvalid && (!i_rvalid || !r_last_wr)) begin
                    w_accept_wr  = 1'b1;
                    w_next_state = S_WR_WAIT;
                end else if (i_rvalid) begin
                    w_accept_rd  = 1'b1;
                    w_next_state = S_RD_WAIT;
                end
            end
            S_RD_WAIT: if (r_lat_cnt == '0) w_next_state = S_RD_RESP;
            S_RD_RESP: w_next_state = S_IDLE;
            S_WR_WAIT: if (r_lat_cnt == '0) w_next_state = S_WR_RESP;
            S_WR_RESP: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    assign w_rd_done = (r_state == S_RD_WAIT) && (w_next_state == S_RD_RESP);
    assign w_wr_done = (r_state == S_WR_WAIT) && (w_next_state == S_WR_RESP);

    // State register, request latches, response pulses and debug counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lat_cnt  <= '0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_wdata    <= '0;
            r_last_wr  <= 1'b0;
            r_rready   <= 1'b0;
            r_wready   <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_err_oob  <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= (w_next_state != S_IDLE);
            r_rready <= w_rd_done;
            r_wready <= w_wr_done;

            if (w_accept_rd) begin
                r_lat_cnt <= LAT_W'(RD_LAT - 1);
            end else if (w_accept_wr) begin
                r_lat_cnt <= LAT_W'(WR_LAT - 1);
            end else if (r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end

            if (w_accept_rd || w_accept_wr) begin
                r_last_wr  <= w_accept_wr;
                r_idx      <= w_off[DEPTH_LOG2-1:0];
                r_in_range <= w_in_range;
                if (!w_in_range) r_err_oob <= 1'b1;
            end
            if (w_accept_wr) r_wdata <= i_wdata;

            // rdata only moves when a read completes, so it holds between pulses.
            if (w_rd_done) begin
                r_rdata    <= r_in_range ? r_mem[r_idx] : '0;
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr_done) r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    // Array write commits at the edge that ends the wready cycle; contents are never reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_WR_RESP) && r_in_range) r_mem[r_idx] <= r_wdata;
    end

    assign o_rready   = r_rready;
    assign o_wready   = r_wready;
    assign o_rdata    = r_rdata;
    assign o_busy     = r_busy;
    assign o_err_oob  = r_err_oob;
    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_cv_mem_responder.sv
// Directed bench for cv_mem_responder (default parameters, no preload image).
module tb_cv_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rvalid;
    logic [25:0] i_raddr;
    logic        o_rready;
    logic [31:0] o_rdata;
    logic        i_wvalid;
    logic [25:0] i_waddr;
    logic [31:0] i_wdata;
    logic        o_wready;
    logic        o_busy;
    logic        o_err_oob;
    logic [31:0] o_rd_count;
    logic [31:0] o_wr_count;

    int errors = 0;
    int checks = 0;

    cv_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .i_rvalid   (i_rvalid),
        .i_raddr    (i_raddr),
        .o_rready   (o_rready),
        .o_rdata    (o_rdata),
        .i_wvalid   (i_wvalid),
        .i_waddr    (i_waddr),
        .i_wdata    (i_wdata),
        .o_wready   (o_wready),
        .o_busy     (o_busy),
        .o_err_oob  (o_err_oob),
        .o_rd_count (o_rd_count),
        .o_wr_count (o_wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_rvalid = 1'b0;
        i_wvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // n = edges from request presentation (accept edge counts as 1) to the pulse.
    task automatic do_write(input logic [25:0] a, input logic [31:0] d, output int n);
        i_wvalid = 1'b1;
        i_waddr  = a;
        i_wdata  = d;
        n = 0;
        while (n < 20 && !o_wready) begin
            tick();
            n++;
        end
        i_wvalid = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [25:0] a, output logic [31:0] d, output int n);
        i_rvalid = 1'b1;
        i_raddr  = a;
        n = 0;
        while (n < 20 && !o_rready) begin
            tick();
            n++;
        end
        d = o_rdata;
        i_rvalid = 1'b0;
        tick();
    endtask

    // Waits for the next rready/wready pulse; kind = 1 read, 2 write, 0 timeout.
    task automatic wait_pulse(output int kind);
        int n;
        n = 0;
        kind = 0;
        while (n < 20 && !o_rready && !o_wready) begin
            tick();
            n++;
        end
        if (o_rready && !o_wready) kind = 1;
        else if (o_wready && !o_rready) kind = 2;
    endtask

    initial begin
        int          n;
        int          k;
        int          cyc;
        int          kind;
        int          pulses;
        logic [31:0] d;

        i_raddr = '0;
        i_waddr = '0;
        i_wdata = '0;

        // T1: reset values
        do_reset();
        check("rst_rready", o_rready, 0);
        check("rst_wready", o_wready, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err_oob, 0);
        check("rst_rdcnt", o_rd_count, 0);
        check("rst_wrcnt", o_wr_count, 0);

        // T2: write then read back, latency and counters
        do_write(26'd5, 32'h0000_1234, n);
        check("t2_wr_lat", n, 2);
        check("t2_wready_off", o_wready, 0);
        check("t2_busy_idle", o_busy, 0);
        do_read(26'd5, d, n);
        check("t2_rd_lat", n, 3);
        check("t2_rdata", d, 32'h0000_1234);
        check("t2_rdata_hold", o_rdata, 32'h0000_1234);
        check("t2_rready_off", o_rready, 0);
        check("t2_wrcnt", o_wr_count, 1);
        check("t2_rdcnt", o_rd_count, 1);

        // T3: preload, reset (array survives), then loader-style held-rvalid stream
        for (int i = 0; i < 16; i++) do_write(26'(i), 32'hA500_0000 + 32'(i), n);
        check("t3_preload_cnt", o_wr_count, 17);
        do_reset();
        check("t3_rst_wrcnt", o_wr_count, 0);
        i_rvalid = 1'b1;
        i_raddr  = '0;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 200) begin
            tick();
            cyc++;
            if (o_rready) begin
                check($sformatf("t3_stream_%0d", k), o_rdata, 32'hA500_0000 + 32'(k));
                k++;
                if (k == 16) i_rvalid = 1'b0;
                else i_raddr = 26'(k);
            end
        end
        check("t3_pulses", k, 16);
        tick();
        check("t3_rdcnt", o_rd_count, 16);
        check("t3_busy_idle", o_busy, 0);

        // T4: simultaneous requests from reset alternate W, R, W
        do_reset();
        i_wvalid = 1'b1; i_waddr = 26'd7; i_wdata = 32'hBEEF_0007;
        i_rvalid = 1'b1; i_raddr = 26'd7;
        wait_pulse(kind);
        check("t4_first_is_wr", kind, 2);
        i_waddr = 26'd8; i_wdata = 32'hCAFE_0008;
        tick();
        wait_pulse(kind);
        check("t4_second_is_rd", kind, 1);
        check("t4_rd_new_data", o_rdata, 32'hBEEF_0007);
        i_rvalid = 1'b0;
        tick();
        wait_pulse(kind);
        check("t4_third_is_wr", kind, 2);
        i_wvalid = 1'b0;
        tick();
        do_read(26'd8, d, n);
        check("t4_rd_second_wr", d, 32'hCAFE_0008);
        check("t4_wrcnt", o_wr_count, 2);

        // T5: top in-range word, then out-of-range read/write
        do_write(26'd4095, 32'h0FFF_0FFF, n);
        do_read(26'd4095, d, n);
        check("t5_top_word", d, 32'h0FFF_0FFF);
        check("t5_no_err_yet", o_err_oob, 0);
        do_read(26'd4096, d, n);
        check("t5_oob_rd_lat", n, 3);
        check("t5_oob_rdata", d, 0);
        check("t5_err_set", o_err_oob, 1);
        do_write(26'd4096, 32'hFFFF_FFFF, n);
        check("t5_oob_wr_lat", n, 2);
        do_read(26'd0, d, n);
        check("t5_idx0_intact", d, 32'hA500_0000);
        check("t5_err_sticky", o_err_oob, 1);

        // T6: reset during RD_WAIT
        i_rvalid = 1'b1; i_raddr = 26'd1;
        tick();
        check("t6_rd_busy", o_busy, 1);
        rst = 1'b1; i_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_rd_busy_clr", o_busy, 0);
        check("t6_err_clr", o_err_oob, 0);
        pulses = 0;
        repeat (4) begin
            if (o_rready) pulses++;
            tick();
        end
        check("t6_no_rready", pulses, 0);

        // T6: reset during WR_WAIT drops the write
        i_wvalid = 1'b1; i_waddr = 26'd2; i_wdata = 32'hDEAD_DEAD;
        tick();
        check("t6_wr_busy", o_busy, 1);
        rst = 1'b1; i_wvalid = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_wr_busy_clr", o_busy, 0);
        pulses = 0;
        repeat (4) begin
            if (o_wready) pulses++;
            tick();
        end
        check("t6_no_wready", pulses, 0);
        do_read(26'd2, d, n);
        check("t6_idx2_intact", d, 32'hA500_0002);
        check("t6_wrcnt", o_wr_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
